coordinate_unwrapper: RTL and testbench



---
 rtl/coordinate_unwrapper_if.sv | 11 +
 rtl/coordinate_unwrapper.sv | 69 ++++++
 tb/tb_coordinate_unwrapper.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/coordinate_unwrapper_if.sv
// coordinate_unwrapper_if: request/result bundle for the field-to-signed coordinate converter
interface coordinate_unwrapper_if;
  logic         ce_in;
  logic [255:0] field_coord;
  logic         busy;
  logic         ce_out;
  logic [255:0] coord;
  logic         coord_err;
  modport master (output ce_in, field_coord, input busy, ce_out, coord, coord_err);
  modport slave (input ce_in, field_coord, output busy, ce_out, coord, coord_err);
endinterface

// File: rtl/coordinate_unwrapper.sv
// coordinate_unwrapper: maps a BN254 field element to a signed 256-bit coordinate, one limb per cycle
module coordinate_unwrapper #(
  parameter int LIMB_WIDTH = 64
) (
  input logic clk,
  input logic rst_n,
  coordinate_unwrapper_if.slave bus
);
  localparam int NUM_LIMBS = 256 / LIMB_WIDTH;
  localparam int IW = NUM_LIMBS > 1 ? $clog2(NUM_LIMBS) : 1;
  localparam logic [255:0] mimc_prime = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [255:0] half = 256'h183227397098d014dc2822db40c0ac2e9419f4243cdcb848a1f0fac9f8000001;
  typedef enum logic {IDLE, SUB} state_t;
  state_t state, state_n;
  logic [255:0] v, d, d_next, coord;
  logic [IW-1:0] idx;
  logic bp, bh, bp_n, bh_n, ce_out, coord_err, last;
  logic [LIMB_WIDTH-1:0] v_l, p_l, h_l, dp_l;
  assign v_l = v[int'(idx) * LIMB_WIDTH +: LIMB_WIDTH];
  assign p_l = mimc_prime[int'(idx) * LIMB_WIDTH +: LIMB_WIDTH];
  assign h_l = half[int'(idx) * LIMB_WIDTH +: LIMB_WIDTH];
  assign {bp_n, dp_l} = {1'b0, v_l} - {1'b0, p_l} - {{LIMB_WIDTH{1'b0}}, bp};
  // Only the sign of v - half matters, so its borrow is tracked as a compare chain
  assign bh_n = (v_l < h_l) || ((v_l == h_l) && bh);
  // Difference limbs enter at the top and shift down, so after the last limb d_next holds v - P
  assign d_next = 256'({dp_l, d} >> LIMB_WIDTH);
  assign last = idx == IW'(NUM_LIMBS - 1);
  always_comb begin
    state_n = state == IDLE ? (bus.ce_in ? SUB : IDLE) : (last ? IDLE : SUB);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      v <= '0;
      d <= '0;
      idx <= '0;
      bp <= 1'b0;
      bh <= 1'b0;
      ce_out <= 1'b0;
      coord <= '0;
      coord_err <= 1'b0;
    end else begin
      state <= state_n;
      ce_out <= 1'b0;
      if (state == IDLE) begin
        if (bus.ce_in) begin
          v <= bus.field_coord;
          bp <= 1'b0;
          bh <= 1'b0;
          idx <= '0;
        end
      end else begin
        bp <= bp_n;
        bh <= bh_n;
        d <= d_next;
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          ce_out <= 1'b1;
          coord_err <= !bp_n;
          coord <= !bp_n ? '0 : (bh_n ? v : d_next);
        end
      end
    end
  end
  assign bus.busy = state == SUB;
  assign bus.ce_out = ce_out;
  assign bus.coord = coord;
  assign bus.coord_err = coord_err;
endmodule

// File: tb/tb_coordinate_unwrapper.sv
// tb_coordinate_unwrapper: directed scoreboard bench over limb widths 64, 32 and 256
module tb_coordinate_unwrapper;
  localparam logic [255:0] P = 256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [255:0] HALF = 256'h183227397098d014dc2822db40c0ac2e9419f4243cdcb848a1f0fac9f8000001;
  typedef struct {
    logic [255:0] c;
    logic e;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce_in_a[3];
  logic [255:0] fa[3];
  logic busy_a[3];
  logic ce_out_a[3];
  logic [255:0] coord_a[3];
  logic err_a[3];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int k = 0;
  int nl[3] = '{4, 8, 1};
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LW = g == 0 ? 64 : (g == 1 ? 32 : 256);
    coordinate_unwrapper_if u_if ();
    assign u_if.ce_in = ce_in_a[g];
    assign u_if.field_coord = fa[g];
    assign busy_a[g] = u_if.busy;
    assign ce_out_a[g] = u_if.ce_out;
    assign coord_a[g] = u_if.coord;
    assign err_a[g] = u_if.coord_err;
    coordinate_unwrapper #(.LIMB_WIDTH(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s lw_idx=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (q.size() > 0 && cyc >= q[0].t) begin
      check("ce_out", 256'(ce_out_a[k]), 256'd1);
      check("coord", coord_a[k], q[0].c);
      check("coord_err", 256'(err_a[k]), 256'(q[0].e));
      void'(q.pop_front());
    end else check("ce_out_idle", 256'(ce_out_a[k]), 256'd0);
  endtask
  task automatic send(input logic [255:0] v);
    exp_t x;
    int n = 0;
    while (busy_a[k] && n < 40) begin
      tick();
      n++;
    end
    if (busy_a[k]) check("busy_timeout", 256'(busy_a[k]), 256'd0);
    ce_in_a[k] = 1'b1;
    fa[k] = v;
    x.e = v >= P;
    x.c = x.e ? '0 : (v >= HALF ? v - P : v);
    x.t = cyc + 1 + nl[k];
    q.push_back(x);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      check("drain_timeout", 256'(q.size()), 256'd0);
      q.delete();
    end
    repeat (nl[k] + 2) tick();
  endtask
  task automatic one(input logic [255:0] v);
    send(v);
    tick();
    ce_in_a[k] = 1'b0;
    drain();
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      ce_in_a[i] = 1'b0;
      fa[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int kk = 0; kk < 3; kk++) begin
      k = kk;
      tick();
      check("rst_busy", 256'(busy_a[k]), 256'd0);
      check("rst_coord", coord_a[k], 256'd0);
      check("rst_err", 256'(err_a[k]), 256'd0);
      send(256'd5);
      tick();
      ce_in_a[k] = 1'b0;
      for (int i = 0; i < nl[k]; i++) begin
        check("busy_hi", 256'(busy_a[k]), 256'd1);
        tick();
      end
      check("busy_lo", 256'(busy_a[k]), 256'd0);
      drain();
      one(P - 256'd1);
      one(P - 256'd42);
      one(HALF - 256'd1);
      one(HALF);
      send(P);
      tick();
      send({256{1'b1}});
      tick();
      send(256'd7);
      tick();
      ce_in_a[k] = 1'b0;
      drain();
      send(P - 256'd1);
      tick();
      fa[k] = 256'd9;
      tick();
      ce_in_a[k] = 1'b0;
      drain();
      send(P - 256'd5);
      tick();
      ce_in_a[k] = 1'b0;
      repeat (nl[k] > 2 ? 2 : nl[k] - 1) tick();
      rst_n = 1'b0;
      #1;
      q.delete();
      check("abort_busy", 256'(busy_a[k]), 256'd0);
      check("abort_ce_out", 256'(ce_out_a[k]), 256'd0);
      check("abort_coord", coord_a[k], 256'd0);
      check("abort_err", 256'(err_a[k]), 256'd0);
      tick();
      rst_n = 1'b1;
      repeat (nl[k] + 2) tick();
      one(256'd3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
